// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - valid/ready/data handshake bundle for one pipeline hop
//
// Purpose: groups the payload handshake of a pipeline stage boundary.
// Signals:
//   valid  payload presented by the producer
//   ready  consumer accepts this cycle
//   data   payload, DATA_W bits
// Modports:
//   master  producer side (drives valid/data, observes ready)
//   slave   consumer side (observes valid/data, drives ready)
interface pipe_stage_skid_if #(
  parameter int DATA_W = 64
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - parametrised pipeline stage register with optional skid buffer
//
// Purpose: carries a payload between two core pipeline stages with a valid/ready
// handshake, global hold, synchronous flush (bubble insert) and a saturating
// stall-cycle counter.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   hold       global stall, freezes all state
//   flush      synchronous kill of stage contents, overrides hold and accept
//   in_if      upstream handshake (slave): valid/data in, ready out
//   out_if     downstream handshake (master): valid/data out, ready in
//   occupancy  number of valid entries (0..2)
//   stall_cnt  saturating count of cycles the stage held a payload it could not pass on
module pipe_stage_skid #(
  parameter int              DATA_W = 64,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter bit              SKID   = 1'b1,
  parameter int              CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             flush,
  pipe_stage_skid_if.slave  in_if,
  pipe_stage_skid_if.master out_if,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic              m_v;
  logic [DATA_W-1:0] m_d;
  logic              s_v;
  logic              acc;
  logic              pop;
  logic              stall_inc;
  logic [1:0]        state;

  assign occupancy    = {1'b0, m_v} + {1'b0, s_v};
  assign state        = occupancy;
  assign out_if.valid = m_v;
  assign out_if.data  = m_v ? m_d : BUBBLE;

  assign acc = in_if.valid && in_if.ready;
  assign pop = m_v && out_if.ready && !hold;

  generate
    if (SKID) begin : g_skid
      logic [DATA_W-1:0] s_d;

      // ready depends only on registered state, breaking the out_ready path
      assign in_if.ready = rst && !hold && !s_v;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          m_v <= 1'b0;
          s_v <= 1'b0;
          m_d <= BUBBLE;
          s_d <= BUBBLE;
        end else if (flush) begin
          m_v <= 1'b0;
          s_v <= 1'b0;
        end else if (!hold) begin
          case (state)
            ST_EMPTY: begin
              if (acc) begin
                m_v <= 1'b1;
                m_d <= in_if.data;
              end
            end
            ST_ONE: begin
              if (acc && pop) begin
                m_d <= in_if.data;
              end else if (acc) begin
                s_v <= 1'b1;
                s_d <= in_if.data;
              end else if (pop) begin
                m_v <= 1'b0;
              end
            end
            ST_FULL: begin
              // skid entry moves up so it is never presented ahead of M
              if (pop) begin
                m_d <= s_d;
                s_v <= 1'b0;
              end
            end
            default: begin
              m_v <= m_v;
            end
          endcase
        end
      end
    end else begin : g_single
      assign s_v         = 1'b0;
      assign in_if.ready = rst && !hold && (!m_v || out_if.ready);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          m_v <= 1'b0;
          m_d <= BUBBLE;
        end else if (flush) begin
          m_v <= 1'b0;
        end else if (acc) begin
          m_v <= 1'b1;
          m_d <= in_if.data;
        end else if (pop) begin
          m_v <= 1'b0;
        end
      end
    end
  endgenerate

  // counts independently of flush so stall statistics survive branch kills
  assign stall_inc = m_v && (!out_if.ready || hold);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed self-checking bench for pipe_stage_skid
module tb_pipe_stage_skid;

  localparam logic [63:0] NOP = 64'h0000_0000_0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // SKID=1 core-style instance
  logic        rst_a, hold_a, flush_a;
  logic [1:0]  occ_a;
  logic [15:0] cnt_a;
  pipe_stage_skid_if #(.DATA_W(64)) a_in ();
  pipe_stage_skid_if #(.DATA_W(64)) a_out ();

  pipe_stage_skid #(.DATA_W(64), .BUBBLE(NOP), .SKID(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst_a), .hold(hold_a), .flush(flush_a),
    .in_if(a_in), .out_if(a_out), .occupancy(occ_a), .stall_cnt(cnt_a)
  );

  // SKID=0 instance with a tiny counter to reach saturation
  logic        rst_b, hold_b, flush_b;
  logic [1:0]  occ_b;
  logic [1:0]  cnt_b;
  pipe_stage_skid_if #(.DATA_W(8)) b_in ();
  pipe_stage_skid_if #(.DATA_W(8)) b_out ();

  pipe_stage_skid #(.DATA_W(8), .BUBBLE(8'h00), .SKID(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst_b), .hold(hold_b), .flush(flush_b),
    .in_if(b_in), .out_if(b_out), .occupancy(occ_b), .stall_cnt(cnt_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b0; hold_a = 1'b0; flush_a = 1'b0;
    a_in.valid = 1'b0; a_in.data = '0; a_out.ready = 1'b0;
    rst_b = 1'b0; hold_b = 1'b0; flush_b = 1'b0;
    b_in.valid = 1'b0; b_in.data = '0; b_out.ready = 1'b0;
    #1;
    check("rst_out_valid", a_out.valid, 0);
    check("rst_out_data", a_out.data, NOP);
    check("rst_in_ready", a_in.ready, 0);
    check("rst_occ", occ_a, 0);
    check("rst_cnt", cnt_a, 0);
    tick(); tick();
    rst_a = 1'b1; rst_b = 1'b1;
    #1;
    check("post_rst_in_ready", a_in.ready, 1);

    // streaming, full throughput
    a_out.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in.valid = 1'b1; a_in.data = 64'(i);
      tick();
      check($sformatf("stream_data%0d", i), a_out.data, 64'(i));
      check($sformatf("stream_occ%0d", i), occ_a, 1);
      check($sformatf("stream_rdy%0d", i), a_in.ready, 1);
    end
    a_in.valid = 1'b0;
    tick();
    check("stream_drain_valid", a_out.valid, 0);
    check("stream_drain_data", a_out.data, NOP);
    check("stream_cnt", cnt_a, 0);

    // backpressure A,B,C with three stalled cycles
    a_in.valid = 1'b1; a_in.data = 64'hA;
    tick();
    check("bp_a_first", a_out.data, 64'hA);
    a_out.ready = 1'b0; a_in.data = 64'hB;
    tick();
    check("bp_occ_full", occ_a, 2);
    check("bp_rdy_full", a_in.ready, 0);
    check("bp_hold_a1", a_out.data, 64'hA);
    a_in.data = 64'hC;
    tick();
    check("bp_hold_a2", a_out.data, 64'hA);
    tick();
    check("bp_hold_a3", a_out.data, 64'hA);
    check("bp_cnt3", cnt_a, 3);
    a_out.ready = 1'b1;
    tick();
    check("bp_b", a_out.data, 64'hB);
    check("bp_occ_one", occ_a, 1);
    tick();
    check("bp_c", a_out.data, 64'hC);
    a_in.valid = 1'b0;
    tick();
    check("bp_empty", a_out.valid, 0);
    check("bp_cnt_keep", cnt_a, 3);

    // hold while FULL
    a_out.ready = 1'b0; a_in.valid = 1'b1; a_in.data = 64'hD;
    tick();
    a_in.data = 64'hE;
    tick();
    check("hold_full", occ_a, 2);
    check("hold_cnt_pre", cnt_a, 4);
    hold_a = 1'b1; a_out.ready = 1'b1; a_in.data = 64'hF;
    #1;
    check("hold_rdy", a_in.ready, 0);
    tick();
    check("hold_d1", a_out.data, 64'hD);
    check("hold_occ1", occ_a, 2);
    tick();
    check("hold_d2", a_out.data, 64'hD);
    check("hold_occ2", occ_a, 2);
    check("hold_cnt", cnt_a, 6);
    hold_a = 1'b0; a_in.valid = 1'b0;
    tick();
    check("hold_e", a_out.data, 64'hE);
    tick();
    check("hold_empty", a_out.valid, 0);
    check("hold_cnt_after", cnt_a, 6);

    // flush while FULL, C offered in the flush cycle
    a_out.ready = 1'b0; a_in.valid = 1'b1; a_in.data = 64'hA;
    tick();
    a_in.data = 64'hB;
    tick();
    check("fl_full", occ_a, 2);
    flush_a = 1'b1; a_in.data = 64'hC;
    tick();
    check("fl_valid", a_out.valid, 0);
    check("fl_data", a_out.data, NOP);
    check("fl_occ", occ_a, 0);
    check("fl_cnt", cnt_a, 8);
    flush_a = 1'b0; a_in.valid = 1'b0; a_out.ready = 1'b1;
    tick();
    check("fl_no_c", a_out.valid, 0);

    // asynchronous reset mid-stream
    a_out.ready = 1'b0; a_in.valid = 1'b1; a_in.data = 64'h1;
    tick();
    a_in.data = 64'h2;
    tick();
    check("mr_full", occ_a, 2);
    #2;
    rst_a = 1'b0;
    #1;
    check("mr_valid", a_out.valid, 0);
    check("mr_data", a_out.data, NOP);
    check("mr_rdy", a_in.ready, 0);
    check("mr_occ", occ_a, 0);
    a_in.valid = 1'b0;
    tick();
    rst_a = 1'b1;
    #1;
    check("mr_rdy_after", a_in.ready, 1);
    check("mr_cnt_after", cnt_a, 0);

    // SKID=0: combinational ready, replace on same-cycle pop, counter saturation
    check("b_empty_data", b_out.data, 0);
    b_in.valid = 1'b1; b_in.data = 8'h11;
    tick();
    check("b_first", b_out.data, 8'h11);
    b_in.data = 8'h22;
    #1;
    check("b_rdy_low", b_in.ready, 0);
    tick();
    check("b_held", b_out.data, 8'h11);
    check("b_cnt1", cnt_b, 1);
    for (int i = 0; i < 4; i++) tick();
    check("b_cnt_sat", cnt_b, 3);
    b_out.ready = 1'b1;
    #1;
    check("b_rdy_high", b_in.ready, 1);
    tick();
    check("b_replace", b_out.data, 8'h22);
    check("b_occ", occ_b, 1);
    b_in.valid = 1'b0;
    tick();
    check("b_drain", b_out.valid, 0);
    check("b_cnt_keep", cnt_b, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
